uart_switch_ctrl: RTL and testbench



---
 rtl/uart_switch_ctrl_if.sv | 21 ++
 rtl/uart_switch_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_switch_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_switch_ctrl_if.sv
// Request handshake between the host control path and the UART switch sequencer.
// The master issues target-node requests; the slave (sequencer) accepts them.
interface uart_switch_ctrl_if #(
  parameter int PITON_N_LOG = 2
) ();
  logic                   req_valid;
  logic [PITON_N_LOG-1:0] req_sel;
  logic                   req_ready;

  modport master (
    output req_valid,
    output req_sel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready
  );
endinterface

// File: rtl/uart_switch_ctrl.sv
// Shell-side UART select sequencer: waits for both UART lines to be quiet, moves sw,
// then holds a settle window so a switch never lands in the middle of a character.
module uart_switch_ctrl #(
  parameter int PITON_N        = 4,
  parameter int PITON_N_LOG    = 2,
  parameter int QUIET_CYCLES   = 1024,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   shell_clk,
  input  logic                   shell_rst_n,
  uart_switch_ctrl_if.slave      req_if,
  input  logic                   shell_tx,
  input  logic                   shell_rx,
  output logic [PITON_N_LOG-1:0] sw,
  output logic                   settling,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int QW       = $clog2(QUIET_CYCLES + 1);
  localparam int SW_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SEL_SPAN = 1 << PITON_N_LOG;

  localparam logic [QW-1:0]   Q_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [SW_W-1:0] S_LAST = SW_W'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    SETTLE
  } state_t;

  state_t                 state_reg, state_next;
  logic [PITON_N_LOG-1:0] sw_reg, sw_next;
  logic [PITON_N_LOG-1:0] tgt_reg, tgt_next;
  logic [QW-1:0]          quiet_cnt_reg, quiet_cnt_next;
  logic [TW-1:0]          tmo_cnt_reg, tmo_cnt_next;
  logic [SW_W-1:0]        settle_cnt_reg, settle_cnt_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;
  logic [1:0]             tx_sync_reg, rx_sync_reg;

  logic [PITON_N_LOG-1:0] req_sel;
  logic                   req_valid;
  logic                   line_idle;
  logic [SEL_SPAN-1:0]    sel_ok;

  assign req_sel   = req_if.req_sel;
  assign req_valid = req_if.req_valid;

  // Per-code legality table, so out-of-range checks stay a plain lookup for any PITON_N.
  generate
    for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_sel_ok
      assign sel_ok[gi] = (gi < PITON_N);
    end
  endgenerate

  // Lines reset to mark so a fresh reset does not look like line activity.
  always_ff @(posedge shell_clk) begin
    if (!shell_rst_n) begin
      tx_sync_reg <= 2'b11;
      rx_sync_reg <= 2'b11;
    end else begin
      tx_sync_reg <= {tx_sync_reg[0], shell_tx};
      rx_sync_reg <= {rx_sync_reg[0], shell_rx};
    end
  end

  assign line_idle = tx_sync_reg[1] & rx_sync_reg[1];

  always_ff @(posedge shell_clk) begin
    if (!shell_rst_n) begin
      state_reg      <= IDLE;
      sw_reg         <= '0;
      tgt_reg        <= '0;
      quiet_cnt_reg  <= '0;
      tmo_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sw_reg         <= sw_next;
      tgt_reg        <= tgt_next;
      quiet_cnt_reg  <= quiet_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sw_next         = sw_reg;
    tgt_next        = tgt_reg;
    quiet_cnt_next  = quiet_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (!sel_ok[req_sel]) begin
            err_next = 1'b1;
          end else if (req_sel == sw_reg) begin
            done_next = 1'b1;
          end else begin
            tgt_next       = req_sel;
            quiet_cnt_next = '0;
            tmo_cnt_next   = '0;
            state_next     = WAIT_QUIET;
          end
        end
      end

      WAIT_QUIET: begin
        tmo_cnt_next   = tmo_cnt_reg + TW'(1);
        quiet_cnt_next = line_idle ? quiet_cnt_reg + QW'(1) : '0;
        // Switching takes priority over a timeout landing on the same cycle.
        if (line_idle && (quiet_cnt_reg == Q_LAST)) begin
          sw_next         = tgt_reg;
          quiet_cnt_next  = '0;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end else if (tmo_cnt_reg == T_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      SETTLE: begin
        settle_cnt_next = settle_cnt_reg + SW_W'(1);
        if (settle_cnt_reg == S_LAST) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_if.req_ready = (state_reg == IDLE);
  assign busy             = (state_reg != IDLE);
  assign settling         = (state_reg == SETTLE);
  assign sw               = sw_reg;
  assign done             = done_reg;
  assign err              = err_reg;

endmodule

// File: tb/tb_uart_switch_ctrl.sv
// Bench for uart_switch_ctrl: directed requests push expected done/err events into a
// queue; a negedge monitor pops and compares them whenever the DUT pulses done or err.
module tb_uart_switch_ctrl;

  localparam int N    = 4;
  localparam int NLOG = 3;
  localparam int Q    = 8;
  localparam int S    = 4;
  localparam int TMO  = 32;

  logic            shell_clk;
  logic            shell_rst_n;
  logic            shell_tx;
  logic            shell_rx;
  logic [NLOG-1:0] sw;
  logic            settling;
  logic            busy;
  logic            done;
  logic            err;

  uart_switch_ctrl_if #(.PITON_N_LOG(NLOG)) req_if ();

  uart_switch_ctrl #(
    .PITON_N        (N),
    .PITON_N_LOG    (NLOG),
    .QUIET_CYCLES   (Q),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .shell_clk   (shell_clk),
    .shell_rst_n (shell_rst_n),
    .req_if      (req_if.slave),
    .shell_tx    (shell_tx),
    .shell_rx    (shell_rx),
    .sw          (sw),
    .settling    (settling),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    int              cyc;
    bit              is_err;
    logic [NLOG-1:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  initial shell_clk = 1'b0;
  always #5 shell_clk = ~shell_clk;

  initial cyc = 0;
  always @(posedge shell_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
    end else begin
      $display("ok   %s cyc=%0d val=%0h", name, cyc, act);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge shell_clk);
  endtask

  task automatic push_exp(input int c, input bit is_err, input logic [NLOG-1:0] s);
    exp_t e;
    e.cyc    = c;
    e.is_err = is_err;
    e.sw     = s;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle request at the current cycle; returns that cycle as T.
  task automatic issue(input logic [NLOG-1:0] sel, output int t);
    t = cyc;
    req_if.req_valid = 1'b1;
    req_if.req_sel   = sel;
    chk("req_ready_at_issue", 32'(req_if.req_ready), 32'd1);
    @(negedge shell_clk);
    req_if.req_valid = 1'b0;
  endtask

  // Monitor: every done/err pulse must match the oldest expected event.
  always @(negedge shell_clk) begin
    if (done || err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event cyc=%0d done=%0b err=%0b sw=%0d want=none", cyc, done, err, sw);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (cyc != e.cyc || err != e.is_err || done == e.is_err || sw != e.sw) begin
          errors++;
          $display("FAIL event cyc=%0d done=%0b err=%0b sw=%0d want cyc=%0d err=%0b sw=%0d",
                   cyc, done, err, sw, e.cyc, e.is_err, e.sw);
        end else begin
          $display("ok   event cyc=%0d %s sw=%0d", cyc, e.is_err ? "err" : "done", sw);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int t2;
    bit seen_settle;

    checks           = 0;
    errors           = 0;
    shell_rst_n      = 1'b0;
    shell_tx         = 1'b1;
    shell_rx         = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_sel   = '0;

    @(negedge shell_clk);
    goto(3);
    chk("rst_sw", 32'(sw), 32'd0);
    chk("rst_req_ready", 32'(req_if.req_ready), 32'd1);
    chk("rst_settling", 32'(settling), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    shell_rst_n = 1'b1;
    goto(6);

    // Same-node and out-of-range requests complete immediately without going busy.
    issue(3'd0, t);
    push_exp(t + 1, 1'b0, 3'd0);
    chk("same_busy", 32'(busy), 32'd0);
    goto(t + 2);
    issue(3'd5, t);
    push_exp(t + 1, 1'b1, 3'd0);
    chk("badsel_busy", 32'(busy), 32'd0);
    chk("badsel_ready", 32'(req_if.req_ready), 32'd1);
    goto(t + 3);
    chk("badsel_sw", 32'(sw), 32'd0);

    // Clean 0->2 switch with idle lines.
    issue(3'd2, t);
    push_exp(t + 13, 1'b0, 3'd2);
    chk("sw02_busy_t1", 32'(busy), 32'd1);
    goto(t + 8);
    chk("sw02_sw_t8", 32'(sw), 32'd0);
    chk("sw02_settling_t8", 32'(settling), 32'd0);
    goto(t + 9);
    chk("sw02_sw_t9", 32'(sw), 32'd2);
    chk("sw02_settling_t9", 32'(settling), 32'd1);
    goto(t + 12);
    chk("sw02_settling_t12", 32'(settling), 32'd1);
    goto(t + 13);
    chk("sw02_settling_t13", 32'(settling), 32'd0);
    chk("sw02_busy_t13", 32'(busy), 32'd0);

    // Back-to-back: next request on the done cycle.
    issue(3'd1, t2);
    push_exp(t2 + 13, 1'b0, 3'd1);
    goto(t2 + 8);
    chk("b2b_sw_before", 32'(sw), 32'd2);
    goto(t2 + 9);
    chk("b2b_sw_after", 32'(sw), 32'd1);
    goto(t2 + 14);

    // One-cycle rx glitch at T+5 restarts the quiet window.
    issue(3'd2, t);
    push_exp(t + 20, 1'b0, 3'd2);
    goto(t + 5);
    shell_rx = 1'b0;
    @(negedge shell_clk);
    shell_rx = 1'b1;
    goto(t + 9);
    chk("glitch_sw_t9", 32'(sw), 32'd1);
    goto(t + 15);
    chk("glitch_sw_t15", 32'(sw), 32'd1);
    goto(t + 16);
    chk("glitch_sw_t16", 32'(sw), 32'd2);
    goto(t + 22);

    // tx held low: request must time out.
    shell_tx = 1'b0;
    goto(cyc + 3);
    seen_settle = 1'b0;
    issue(3'd0, t);
    push_exp(t + 33, 1'b1, 3'd2);
    while (cyc < t + 32) begin
      if (settling) seen_settle = 1'b1;
      @(negedge shell_clk);
    end
    chk("tmo_busy_t32", 32'(busy), 32'd1);
    goto(t + 33);
    chk("tmo_busy_t33", 32'(busy), 32'd0);
    chk("tmo_sw", 32'(sw), 32'd2);
    chk("tmo_no_settle", 32'(seen_settle), 32'd0);
    shell_tx = 1'b1;
    goto(t + 38);

    // Reset during SETTLE of a 0->3 switch discards it.
    shell_rst_n = 1'b0;
    @(negedge shell_clk);
    shell_rst_n = 1'b1;
    goto(cyc + 3);
    chk("pre3_sw", 32'(sw), 32'd0);
    issue(3'd3, t);
    goto(t + 10);
    chk("mid_settle", 32'(settling), 32'd1);
    shell_rst_n = 1'b0;
    @(negedge shell_clk);
    shell_rst_n = 1'b1;
    chk("rstmid_sw", 32'(sw), 32'd0);
    chk("rstmid_settling", 32'(settling), 32'd0);
    chk("rstmid_ready", 32'(req_if.req_ready), 32'd1);
    goto(t + 25);

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
